// File: rtl/commit_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : commit_buffer_pkg
//  Description : Shared bus types for the execution-result channel and the
//                in-order commit buffer: Result (57 b), CommitInfo (37 b),
//                CommitSlot (kind + 48 b payload) and the retire decision.
//  Revision    : 1.0 - initial release
// ============================================================================
package commit_buffer_pkg;

  localparam int COMMIT_ID_W = 8;
  localparam int PC_W        = 16;
  localparam int DATA_W      = 32;
  localparam int LOGIC_W     = 5;
  localparam int PHYS_W      = 6;
  localparam int BUF_W       = 5;
  localparam int PAYLOAD_W   = 48;

  // Result / slot kind
  typedef enum logic {
    KIND_WB     = 1'b0,
    KIND_BRANCH = 1'b1
  } kind_e;

  // Writeback view of a Result payload (48 bits)
  typedef struct packed {
    logic [LOGIC_W-1:0] dest_logic;
    logic [PHYS_W-1:0]  dest_phys;
    logic [BUF_W-1:0]   buf_;
    logic [DATA_W-1:0]  data;
  } result_wb_t;

  // Branch view, shared by Result and CommitSlot payloads (48 bits)
  typedef struct packed {
    logic [29:0]       rsvd;
    logic              miss;
    logic              taken;
    logic [PC_W-1:0]   new_pc;
  } branch_t;

  typedef union packed {
    result_wb_t wb;
    branch_t    branch;
  } result_payload_u;

  // Execution-unit result message (57 bits)
  typedef struct packed {
    logic [COMMIT_ID_W-1:0] commit_id;
    kind_e                  kind;
    result_payload_u        u;
  } Result;

  // Retired writeback
  typedef struct packed {
    logic [LOGIC_W-1:0] dest_logic;
    logic [DATA_W-1:0]  data;
  } CommitInfo;

  // Writeback view of a stored slot: only what retirement needs
  typedef struct packed {
    logic [10:0]        rsvd;
    logic [LOGIC_W-1:0] dest_logic;
    logic [DATA_W-1:0]  data;
  } slot_wb_t;

  typedef union packed {
    slot_wb_t wb;
    branch_t  branch;
  } slot_payload_u;

  typedef struct packed {
    kind_e         kind;
    slot_payload_u u;
  } CommitSlot;

  // What the head slot does this cycle
  typedef enum logic [1:0] {
    RET_NONE  = 2'd0,
    RET_WB    = 2'd1,
    RET_BP    = 2'd2,
    RET_FLUSH = 2'd3
  } retire_e;

  // Strip the routing fields (dest_phys, buf_) and keep what retirement uses.
  function automatic CommitSlot to_slot(input Result r);
    CommitSlot s;
    s.kind = r.kind;
    if (r.kind == KIND_WB) begin
      s.u.wb.rsvd       = '0;
      s.u.wb.dest_logic = r.u.wb.dest_logic;
      s.u.wb.data       = r.u.wb.data;
    end else begin
      s.u.branch = r.u.branch;
    end
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/commit_buffer_slot_array.sv
`default_nettype none
// ============================================================================
//  Module      : commit_slot_array
//  Description : DEPTH commit slots. Each slot has a valid bit, a done bit and
//                a CommitSlot payload. Ports:
//                  alloc_en/alloc_idx     - mark a slot valid, not done
//                  wr_en/wr_idx/wr_slot   - store a result into a valid,
//                                           not-yet-done slot (else dropped)
//                  retire_en/retire_idx   - release the retired head slot
//                  clear_all              - drop every slot (flush)
//                  head_idx -> head_valid/head_done/head_slot (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module commit_slot_array
  import commit_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             alloc_en,
  input  logic [IDX_W-1:0] alloc_idx,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  CommitSlot        wr_slot,
  input  logic             retire_en,
  input  logic [IDX_W-1:0] retire_idx,
  input  logic             clear_all,
  input  logic [IDX_W-1:0] head_idx,
  output logic             head_valid,
  output logic             head_done,
  output CommitSlot        head_slot
);

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] done;
  CommitSlot        slots [DEPTH];
  logic             wr_hit;

  // Only the first result for a live slot lands; stale and duplicate
  // results are silently discarded.
  assign wr_hit = wr_en && valid[wr_idx] && !done[wr_idx];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      valid <= '0;
      done  <= '0;
    end else if (clear_all) begin
      valid <= '0;
      done  <= '0;
    end else begin
      // The head only equals the tail when the buffer is empty (no retire)
      // or full (no alloc), so these never target the same slot.
      if (retire_en) begin
        valid[retire_idx] <= 1'b0;
        done[retire_idx]  <= 1'b0;
      end
      if (alloc_en) begin
        valid[alloc_idx] <= 1'b1;
        done[alloc_idx]  <= 1'b0;
      end
      if (wr_hit) begin
        done[wr_idx] <= 1'b1;
      end
    end
  end

  // Payload is qualified by done, so it needs no reset.
  always_ff @(posedge clk) begin
    if (wr_hit && !clear_all) begin
      slots[wr_idx] <= wr_slot;
    end
  end

  assign head_valid = valid[head_idx];
  assign head_done  = done[head_idx];
  assign head_slot  = slots[head_idx];

endmodule
`default_nettype wire

// File: rtl/commit_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : commit_buffer
//  Description : In-order retirement buffer. Grants a commit_id per dispatched
//                instruction, absorbs out-of-order Results into the matching
//                slot and retires the head slot once it is done.
//  Ports       : clk, nrst (async, active-low)
//                alloc_en -> alloc_full, alloc_id      dispatch allocation
//                result_en, result_msg -> result_reject  Result receiver
//                commit_en, commit_info                 retired writeback
//                bp_en, bp_taken, bp_pc                 predictor update
//                flush, redirect_pc                     mispredict squash
//  Revision    : 1.0 - initial release
// ============================================================================
module commit_buffer
  import commit_buffer_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   alloc_en,
  output logic                   alloc_full,
  output logic [COMMIT_ID_W-1:0] alloc_id,
  input  logic                   result_en,
  input  Result                  result_msg,
  output logic                   result_reject,
  output logic                   commit_en,
  output CommitInfo              commit_info,
  output logic                   bp_en,
  output logic                   bp_taken,
  output logic [PC_W-1:0]        bp_pc,
  output logic                   flush,
  output logic [PC_W-1:0]        redirect_pc
);

  localparam int               IDX_W      = $clog2(DEPTH);
  localparam int               CNT_W      = IDX_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic             head_valid;
  logic             head_done;
  CommitSlot        head_slot;
  retire_e          retire_kind;

  logic             alloc_ok;
  logic             flush_dec;
  logic             retire_pop;
  logic             slot_alloc;
  logic             slot_wr;
  logic             unused_bits;

  // Full comes from the registered count only: a retire in the same cycle
  // does not open a slot until the next cycle.
  assign alloc_full    = (count == FULL_COUNT);
  assign alloc_id      = COMMIT_ID_W'(tail);
  assign alloc_ok      = alloc_en && !alloc_full;
  assign result_reject = flush;

  // Head decision
  always_comb begin
    retire_kind = RET_NONE;
    if (head_valid && head_done) begin
      if (head_slot.kind == KIND_WB) begin
        retire_kind = RET_WB;
      end else if (head_slot.u.branch.miss) begin
        retire_kind = RET_FLUSH;
      end else begin
        retire_kind = RET_BP;
      end
    end
  end

  assign flush_dec  = (retire_kind == RET_FLUSH);
  assign retire_pop = (retire_kind == RET_WB) || (retire_kind == RET_BP);

  // A flush decision squashes anything accepted in the same cycle, including
  // an allocation whose id was already handed out.
  assign slot_alloc = alloc_ok && !flush_dec;
  assign slot_wr    = result_en && !result_reject && !flush_dec;

  commit_slot_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_slots (
    .clk        (clk),
    .nrst       (nrst),
    .alloc_en   (slot_alloc),
    .alloc_idx  (tail),
    .wr_en      (slot_wr),
    .wr_idx     (result_msg.commit_id[IDX_W-1:0]),
    .wr_slot    (to_slot(result_msg)),
    .retire_en  (retire_pop),
    .retire_idx (head),
    .clear_all  (flush_dec),
    .head_idx   (head),
    .head_valid (head_valid),
    .head_done  (head_done),
    .head_slot  (head_slot)
  );

  // Pointers and occupancy
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_dec) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (slot_alloc) begin
        tail <= tail + IDX_W'(1);
      end
      if (retire_pop) begin
        head <= head + IDX_W'(1);
      end
      case ({slot_alloc, retire_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered retire outputs: one-cycle pulses, payloads zero when idle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      commit_en   <= 1'b0;
      commit_info <= '0;
      bp_en       <= 1'b0;
      bp_taken    <= 1'b0;
      bp_pc       <= '0;
      flush       <= 1'b0;
      redirect_pc <= '0;
    end else begin
      commit_en   <= (retire_kind == RET_WB);
      bp_en       <= (retire_kind == RET_BP);
      flush       <= (retire_kind == RET_FLUSH);
      commit_info <= '0;
      bp_taken    <= 1'b0;
      bp_pc       <= '0;
      redirect_pc <= '0;
      case (retire_kind)
        RET_WB: begin
          commit_info.dest_logic <= head_slot.u.wb.dest_logic;
          commit_info.data       <= head_slot.u.wb.data;
        end
        RET_BP: begin
          bp_taken <= head_slot.u.branch.taken;
          bp_pc    <= head_slot.u.branch.new_pc;
        end
        RET_FLUSH: begin
          redirect_pc <= head_slot.u.branch.new_pc;
        end
        default: ;
      endcase
    end
  end

  // Routing fields, id bits above the slot index and reserved payload bits
  // are not needed here.
  assign unused_bits = ^{result_msg, head_slot};

endmodule
`default_nettype wire

// File: tb/tb_commit_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_commit_buffer
//  Description : Self-checking bench for commit_buffer (DEPTH=16): directed
//                vector table, hand-written corner sequences and a randomized
//                run against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_commit_buffer;
  import commit_buffer_pkg::*;

  localparam int DEPTH = 16;

  logic        clk;
  logic        nrst;
  logic        alloc_en;
  logic        alloc_full;
  logic [7:0]  alloc_id;
  logic        result_en;
  Result       result_msg;
  logic        result_reject;
  logic        commit_en;
  CommitInfo   commit_info;
  logic        bp_en;
  logic        bp_taken;
  logic [15:0] bp_pc;
  logic        flush;
  logic [15:0] redirect_pc;

  commit_buffer #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .nrst          (nrst),
    .alloc_en      (alloc_en),
    .alloc_full    (alloc_full),
    .alloc_id      (alloc_id),
    .result_en     (result_en),
    .result_msg    (result_msg),
    .result_reject (result_reject),
    .commit_en     (commit_en),
    .commit_info   (commit_info),
    .bp_en         (bp_en),
    .bp_taken      (bp_taken),
    .bp_pc         (bp_pc),
    .flush         (flush),
    .redirect_pc   (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic Result mk_wb(input int id, input int dl, input logic [31:0] data);
    Result r;
    r = '0;
    r.commit_id       = 8'(id);
    r.kind            = KIND_WB;
    r.u.wb.dest_logic = 5'(dl);
    r.u.wb.dest_phys  = 6'(id * 3 + 1);
    r.u.wb.buf_       = 5'(id + 2);
    r.u.wb.data       = data;
    return r;
  endfunction

  function automatic Result mk_br(input int id, input logic miss, input logic taken,
                                  input logic [15:0] pc);
    Result r;
    r = '0;
    r.commit_id       = 8'(id);
    r.kind            = KIND_BRANCH;
    r.u.branch.miss   = miss;
    r.u.branch.taken  = taken;
    r.u.branch.new_pc = pc;
    return r;
  endfunction

  // ---------------------------------------------------------------- vectors
  // Inputs are applied for one cycle; e_id/e_full/e_rej are checked before the
  // edge, the retire outputs right after it.
  typedef struct {
    logic        a;
    logic        r;
    Result       m;
    logic [7:0]  e_id;
    logic        e_full;
    logic        e_rej;
    logic        e_commit;
    logic [4:0]  e_dl;
    logic [31:0] e_data;
    logic        e_bp;
    logic        e_taken;
    logic [15:0] e_bpc;
    logic        e_flush;
    logic [15:0] e_rpc;
  } vec_t;

  vec_t tbl [40];
  int   ntbl = 0;

  task automatic add(input logic a, input logic r, input Result m, input int eid);
    vec_t t;
    t.a = a;        t.r = r;          t.m = m;
    t.e_id = 8'(eid);
    t.e_full = 1'b0; t.e_rej = 1'b0;
    t.e_commit = 1'b0; t.e_dl = '0;   t.e_data = '0;
    t.e_bp = 1'b0;  t.e_taken = 1'b0; t.e_bpc = '0;
    t.e_flush = 1'b0; t.e_rpc = '0;
    tbl[ntbl] = t;
    ntbl++;
  endtask

  task automatic ex_commit(input int dl, input logic [31:0] data);
    tbl[ntbl-1].e_commit = 1'b1;
    tbl[ntbl-1].e_dl     = 5'(dl);
    tbl[ntbl-1].e_data   = data;
  endtask

  task automatic ex_bp(input logic taken, input logic [15:0] pc);
    tbl[ntbl-1].e_bp    = 1'b1;
    tbl[ntbl-1].e_taken = taken;
    tbl[ntbl-1].e_bpc   = pc;
  endtask

  task automatic ex_flush(input logic [15:0] pc);
    tbl[ntbl-1].e_flush = 1'b1;
    tbl[ntbl-1].e_rpc   = pc;
  endtask

  task automatic do_reset();
    alloc_en   = 1'b0;
    result_en  = 1'b0;
    result_msg = '0;
    nrst       = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ------------------------------------------------------- reference model
  typedef struct {
    int          id;
    bit          done;
    bit          is_br;
    bit          miss;
    bit          taken;
    logic [15:0] pc;
    logic [4:0]  dl;
    logic [31:0] data;
  } ment_t;

  ment_t       mq[$];
  int          m_next;
  bit          m_commit, m_bp, m_bp_taken, m_flush;
  logic [4:0]  m_dl;
  logic [31:0] m_data;
  logic [15:0] m_bp_pc, m_rpc;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ------------------------------------------------------ table contents
    // out-of-order writebacks, ids 0..2
    add(1, 0, '0, 0);
    add(1, 0, '0, 1);
    add(1, 0, '0, 2);
    add(0, 1, mk_wb(2, 7, 32'hC), 3);
    add(0, 1, mk_wb(0, 5, 32'hA), 3);
    add(0, 1, mk_wb(1, 6, 32'hB), 3);    ex_commit(5, 32'hA);
    add(0, 0, '0, 3);                    ex_commit(6, 32'hB);
    add(0, 0, '0, 3);                    ex_commit(7, 32'hC);
    add(0, 0, '0, 3);
    // mispredict: ids 3,4,5; id 4 misses
    add(1, 0, '0, 3);
    add(1, 0, '0, 4);
    add(1, 0, '0, 5);
    add(0, 1, mk_wb(3, 1, 32'h11), 6);
    add(0, 1, mk_br(4, 1'b1, 1'b0, 16'h0040), 6);  ex_commit(1, 32'h11);
    add(1, 0, '0, 6);                    ex_flush(16'h0040);   // granted but squashed
    add(0, 1, mk_wb(5, 9, 32'h55), 0);   tbl[ntbl-1].e_rej = 1'b1;
    add(1, 0, '0, 0);
    add(0, 1, mk_wb(0, 2, 32'h22), 1);
    add(0, 0, '0, 1);                    ex_commit(2, 32'h22);
    // correctly predicted branch
    add(1, 0, '0, 1);
    add(0, 1, mk_br(1, 1'b0, 1'b1, 16'h0123), 2);
    add(0, 0, '0, 2);                    ex_bp(1'b1, 16'h0123);
    add(0, 0, '0, 2);
    // duplicate and unallocated results
    add(1, 0, '0, 2);
    add(1, 0, '0, 3);
    add(0, 1, mk_wb(3, 3, 32'h33), 4);
    add(0, 1, mk_wb(3, 4, 32'h44), 4);
    add(0, 1, mk_wb(9, 8, 32'h99), 4);
    add(0, 1, mk_wb(2, 2, 32'h2222), 4);
    add(0, 0, '0, 4);                    ex_commit(2, 32'h2222);
    add(0, 0, '0, 4);                    ex_commit(3, 32'h33);
    add(0, 0, '0, 4);
    add(0, 0, '0, 4);

    // ------------------------------------------------------ reset state
    do_reset();
    check("reset alloc_full", alloc_full, 0);
    check("reset alloc_id", alloc_id, 0);
    check("reset commit_en", commit_en, 0);
    check("reset bp_en", bp_en, 0);
    check("reset flush", flush, 0);
    check("reset result_reject", result_reject, 0);

    // ------------------------------------------------------ table run
    for (int i = 0; i < ntbl; i++) begin
      alloc_en   = tbl[i].a;
      result_en  = tbl[i].r;
      result_msg = tbl[i].m;
      #1;
      check($sformatf("v%0d alloc_id", i), alloc_id, tbl[i].e_id);
      check($sformatf("v%0d alloc_full", i), alloc_full, tbl[i].e_full);
      check($sformatf("v%0d result_reject", i), result_reject, tbl[i].e_rej);
      tick();
      check($sformatf("v%0d commit_en", i), commit_en, tbl[i].e_commit);
      if (tbl[i].e_commit) begin
        check($sformatf("v%0d dest_logic", i), commit_info.dest_logic, tbl[i].e_dl);
        check($sformatf("v%0d data", i), commit_info.data, tbl[i].e_data);
      end
      check($sformatf("v%0d bp_en", i), bp_en, tbl[i].e_bp);
      if (tbl[i].e_bp) begin
        check($sformatf("v%0d bp_taken", i), bp_taken, tbl[i].e_taken);
        check($sformatf("v%0d bp_pc", i), bp_pc, tbl[i].e_bpc);
      end
      check($sformatf("v%0d flush", i), flush, tbl[i].e_flush);
      if (tbl[i].e_flush) begin
        check($sformatf("v%0d redirect_pc", i), redirect_pc, tbl[i].e_rpc);
      end
    end
    alloc_en  = 1'b0;
    result_en = 1'b0;

    // ------------------------------------------------------ full and wrap
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      alloc_en = 1'b1;
      #1;
      check("fill alloc_id", alloc_id, i);
      check("fill alloc_full", alloc_full, 0);
      tick();
    end
    check("full alloc_full", alloc_full, 1);
    alloc_en = 1'b1;                          // 17th request, must be ignored
    tick();
    alloc_en = 1'b0;
    check("full after ignored alloc", alloc_full, 1);
    result_en  = 1'b1;
    result_msg = mk_wb(0, 4, 32'hA0);
    tick();
    result_en = 1'b0;
    check("full while head resolves", alloc_full, 1);
    check("no early commit", commit_en, 0);
    tick();
    check("wrap commit_en", commit_en, 1);
    check("wrap commit data", commit_info.data, 32'hA0);
    check("full falls after retire", alloc_full, 0);
    check("wrap alloc_id", alloc_id, 0);
    alloc_en = 1'b1;
    tick();
    alloc_en = 1'b0;
    #1;
    check("alloc_id after wrap", alloc_id, 1);
    check("full again", alloc_full, 1);

    // ------------------------------------------------------ async reset
    do_reset();
    for (int i = 0; i < 5; i++) begin
      alloc_en = 1'b1;
      tick();
    end
    alloc_en   = 1'b0;
    result_en  = 1'b1;
    result_msg = mk_wb(0, 10, 32'h100);
    tick();
    result_msg = mk_wb(1, 11, 32'h101);
    tick();
    result_en = 1'b0;
    check("pre-reset commit_en", commit_en, 1);
    #1 nrst = 1'b0;
    #1;
    check("async commit_en", commit_en, 0);
    check("async commit_info", commit_info, 0);
    check("async bp_en", bp_en, 0);
    check("async bp_taken", bp_taken, 0);
    check("async bp_pc", bp_pc, 0);
    check("async flush", flush, 0);
    check("async redirect_pc", redirect_pc, 0);
    check("async alloc_full", alloc_full, 0);
    check("async alloc_id", alloc_id, 0);
    check("async result_reject", result_reject, 0);
    tick();
    check("no retire in reset", commit_en, 0);
    @(negedge clk);
    nrst = 1'b1;
    tick();
    check("no retire after reset", commit_en, 0);
    alloc_en = 1'b1;
    #1;
    check("first id after reset", alloc_id, 0);
    tick();
    alloc_en = 1'b0;
    #1;
    check("second id after reset", alloc_id, 1);
    tick();
    check("fresh slot not committed", commit_en, 0);

    // ------------------------------------------------------ random vs model
    do_reset();
    mq.delete();
    m_next = 0;
    m_commit = 0; m_bp = 0; m_bp_taken = 0; m_flush = 0;
    m_dl = '0; m_data = '0; m_bp_pc = '0; m_rpc = '0;
    for (int cyc = 0; cyc < 2500; cyc++) begin
      int    cand[$];
      int    id;
      int    widx;
      bit    a, re, full, dec_flush, pop;
      Result msg;

      a  = ($urandom_range(0, 3) != 0);
      re = ($urandom_range(0, 2) != 0);
      foreach (mq[k]) if (!mq[k].done) cand.push_back(mq[k].id);
      if (cand.size() > 0 && $urandom_range(0, 3) != 0)
        id = cand[$urandom_range(0, cand.size() - 1)];
      else
        id = $urandom_range(0, DEPTH - 1);
      id = id + DEPTH * $urandom_range(0, 256 / DEPTH - 1);
      if ($urandom_range(0, 2) == 0)
        msg = mk_br(id, ($urandom_range(0, 5) == 0), 1'($urandom), 16'($urandom));
      else
        msg = mk_wb(id, $urandom_range(0, 31), $urandom);
      msg.u.wb.dest_phys = msg.kind == KIND_WB ? 6'($urandom) : msg.u.wb.dest_phys;

      alloc_en   = a;
      result_en  = re;
      result_msg = msg;
      #1;
      full = (mq.size() == DEPTH);
      check("rnd alloc_id", alloc_id, m_next);
      check("rnd alloc_full", alloc_full, full);
      check("rnd result_reject", result_reject, m_flush);

      // next-cycle expectations from the pre-edge contents
      m_commit = 0; m_bp = 0; dec_flush = 0; pop = 0;
      if (mq.size() > 0 && mq[0].done) begin
        if (!mq[0].is_br) begin
          m_commit = 1; m_dl = mq[0].dl; m_data = mq[0].data; pop = 1;
        end else if (!mq[0].miss) begin
          m_bp = 1; m_bp_taken = mq[0].taken; m_bp_pc = mq[0].pc; pop = 1;
        end else begin
          dec_flush = 1; m_rpc = mq[0].pc;
        end
      end
      if (dec_flush) begin
        mq.delete();
        m_next = 0;
      end else begin
        if (re && !m_flush) begin
          widx = int'(msg.commit_id) % DEPTH;
          foreach (mq[k]) begin
            if (mq[k].id == widx && !mq[k].done) begin
              ment_t t;
              t       = mq[k];
              t.done  = 1;
              t.is_br = (msg.kind == KIND_BRANCH);
              t.miss  = msg.u.branch.miss;
              t.taken = msg.u.branch.taken;
              t.pc    = msg.u.branch.new_pc;
              t.dl    = msg.u.wb.dest_logic;
              t.data  = msg.u.wb.data;
              mq[k]   = t;
            end
          end
        end
        if (pop) void'(mq.pop_front());
        if (a && !full) begin
          ment_t t;
          t = '{id: m_next, done: 0, is_br: 0, miss: 0, taken: 0,
                pc: '0, dl: '0, data: '0};
          mq.push_back(t);
          m_next = (m_next + 1) % DEPTH;
        end
      end
      m_flush = dec_flush;

      tick();
      check("rnd commit_en", commit_en, m_commit);
      if (m_commit) begin
        check("rnd dest_logic", commit_info.dest_logic, m_dl);
        check("rnd data", commit_info.data, m_data);
      end
      check("rnd bp_en", bp_en, m_bp);
      if (m_bp) begin
        check("rnd bp_taken", bp_taken, m_bp_taken);
        check("rnd bp_pc", bp_pc, m_bp_pc);
      end
      check("rnd flush", flush, m_flush);
      if (m_flush) check("rnd redirect_pc", redirect_pc, m_rpc);
    end
    alloc_en  = 1'b0;
    result_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
